// File: rtl/uart_query_initiator.sv
// Sends one opcode byte (8N1, or 8E1 when UART_QUERY_PARITY_EN is defined), then waits for one reply byte or a timeout.
// One exchange at a time: cmd_ready is high only in IDLE, and cmd_valid is ignored while busy.
module uart_query_initiator #(
  parameter int CLKS_PER_BIT      = 868,
  parameter int RESP_TIMEOUT_CLKS = 200000
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_opcode,
  output logic       cmd_ready,
  output logic       tx_serial,
  input  logic       rx_serial,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       resp_timeout,
  output logic       busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = (RESP_TIMEOUT_CLKS > 1) ? $clog2(RESP_TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RESP_TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_QUERY_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP,
    WAIT_RESP,
    RX_START,
    RX_DATA,
`ifdef UART_QUERY_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       opcode;
  logic [7:0]       rx_shift;
  logic             err_flag;
  logic             rx_meta;
  logic             rx_sync;
`ifdef UART_QUERY_PARITY_EN
  logic             par_err;
`endif

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      to_cnt       <= '0;
      opcode       <= '0;
      rx_shift     <= '0;
      err_flag     <= 1'b0;
`ifdef UART_QUERY_PARITY_EN
      par_err      <= 1'b0;
`endif
      tx_serial    <= 1'b1;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          // cmd_ready clears on accept so it always mirrors "state is IDLE and free"
          if (cmd_valid && cmd_ready) begin
            opcode    <= cmd_opcode;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            state     <= TX_START;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        TX_START: begin
          tx_serial <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          tx_serial <= opcode[bit_idx];
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_QUERY_PARITY_EN
              state <= TX_PARITY;
`else
              state <= TX_STOP;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_QUERY_PARITY_EN
        TX_PARITY: begin
          tx_serial <= ^opcode;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            state   <= TX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          tx_serial <= 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            state   <= WAIT_RESP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_RESP: begin
          // a start edge beats a simultaneous expiry
          if (!rx_sync) begin
            bit_cnt <= '0;
            state   <= RX_START;
          end else if (to_cnt == TO_LAST) begin
            resp_timeout <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_BIT) begin
            bit_cnt <= '0;
            if (!rx_sync) begin
              bit_idx <= '0;
              state   <= RX_DATA;
            end else begin
              state <= WAIT_RESP;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_QUERY_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_QUERY_PARITY_EN
        RX_PARITY: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            par_err <= rx_sync ^ (^rx_shift);
            state   <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
`ifdef UART_QUERY_PARITY_EN
            err_flag <= ~rx_sync | par_err;
`else
            err_flag <= ~rx_sync;
`endif
            state <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          resp_data  <= rx_shift;
          resp_valid <= 1'b1;
          resp_err   <= err_flag;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_query_initiator.sv
// Directed bench for uart_query_initiator with CLKS_PER_BIT=4 and RESP_TIMEOUT_CLKS=100.
module tb_uart_query_initiator;
  localparam int CPB = 4;
  localparam int TO  = 100;
`ifdef UART_QUERY_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_opcode = 8'h00;
  logic       cmd_ready;
  logic       tx_serial;
  logic       rx_serial = 1'b1;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       resp_timeout;
  logic       busy;

  int total = 0;
  int bad = 0;
  int rv_seen = 0;
  int to_seen = 0;

  uart_query_initiator #(.CLKS_PER_BIT(CPB), .RESP_TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset_b(reset_b), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .cmd_ready(cmd_ready), .tx_serial(tx_serial), .rx_serial(rx_serial),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_timeout(resp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_valid) rv_seen++;
    if (resp_timeout) to_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic stop, input logic pflip);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_QUERY_PARITY_EN
    f[9] = (^d) ^ pflip;
    f[10] = stop;
`else
    f[9] = stop;
`endif
    return f;
  endfunction

  // waits for cmd_ready, offers op for the accept edge, then checks every tx cycle of the frame
  task automatic send_cmd(input logic [7:0] op, input logic hold_valid);
    logic [10:0] fr;
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 10) begin tick(); w++; end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready); end
    fr = make_frame(op, 1'b1, 1'b0);
    cmd_valid = 1'b1;
    cmd_opcode = op;
    tick();
    if (hold_valid) cmd_opcode = ~op;
    else cmd_valid = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      for (int j = 0; j < CPB; j++) begin
        tick();
        total++;
        if (tx_serial !== fr[k]) begin
          bad++;
          $display("FAIL tx_bit op=%02h bit=%0d cyc=%0d: got %b want %b", op, k, j, tx_serial, fr[k]);
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input logic pflip);
    logic [10:0] fr;
    fr = make_frame(d, stop, pflip);
    for (int k = 0; k < NBITS; k++) begin
      rx_serial = fr[k];
      repeat (CPB) tick();
    end
    rx_serial = 1'b1;
  endtask

  task automatic expect_resp(input string nm, input logic [7:0] exp_d, input logic exp_e, input int to_base);
    int hit;
    int pulses;
    logic [7:0] d;
    logic e;
    hit = -1;
    pulses = 0;
    d = 'x;
    e = 'x;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (hit >= 0 && i == hit + 1) begin
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_after: got %b want 1", nm, cmd_ready); end
      end
      if (resp_valid === 1'b1) begin
        pulses++;
        if (hit < 0) begin hit = i; d = resp_data; e = resp_err; end
      end
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL %s_pulses: got %0d want 1", nm, pulses); end
    total++;
    if (d !== exp_d) begin bad++; $display("FAIL %s_data: got %02h want %02h", nm, d, exp_d); end
    total++;
    if (e !== exp_e) begin bad++; $display("FAIL %s_err: got %b want %b", nm, e, exp_e); end
    total++;
    if (resp_data !== exp_d) begin bad++; $display("FAIL %s_data_hold: got %02h want %02h", nm, resp_data, exp_d); end
    total++;
    if (to_seen !== to_base) begin bad++; $display("FAIL %s_no_timeout: got %0d want %0d", nm, to_seen, to_base); end
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) tick();
    total++; if (tx_serial !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx_serial); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    total++; if (resp_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %02h want 00", resp_data); end
    total++; if (resp_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", resp_timeout); end
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_query();
    int t0;
    t0 = to_seen;
    send_cmd(8'hA5, 1'b0);
    send_rx(8'h3C, 1'b1, 1'b0);
    expect_resp("q3c", 8'h3C, 1'b0, t0);
  endtask

  task automatic test_timeout();
    int n;
    int r0;
    r0 = rv_seen;
    send_cmd(8'h01, 1'b0);
    // state leaves TX_STOP one cycle before the stop bit finishes on the line
    n = 0;
    while (resp_timeout !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (n !== TO) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", n, TO); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
    tick();
    total++;
    if (resp_timeout !== 1'b0) begin bad++; $display("FAIL timeout_width: got %b want 0", resp_timeout); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL timeout_idle: got %b want 1", cmd_ready); end
    total++;
    if (rv_seen !== r0) begin bad++; $display("FAIL timeout_no_valid: got %0d want %0d", rv_seen, r0); end
  endtask

  task automatic test_framing_err();
    int t0;
    t0 = to_seen;
    send_cmd(8'h22, 1'b0);
    send_rx(8'h7E, 1'b0, 1'b0);
    expect_resp("frm", 8'h7E, 1'b1, t0);
  endtask

  task automatic test_glitch_busy();
    int t0;
    int r0;
    t0 = to_seen;
    r0 = rv_seen;
    send_cmd(8'h96, 1'b1);
    repeat (9) tick();
    rx_serial = 1'b0;
    tick();
    rx_serial = 1'b1;
    repeat (30) tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %b want 1", busy); end
    total++;
    if (rv_seen !== r0) begin bad++; $display("FAIL glitch_no_valid: got %0d want %0d", rv_seen, r0); end
    send_rx(8'hC3, 1'b1, 1'b0);
    expect_resp("glitch", 8'hC3, 1'b0, t0);
  endtask

  task automatic test_reset_mid();
    int t0;
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 10) begin tick(); w++; end
    cmd_valid = 1'b1;
    cmd_opcode = 8'hA5;
    tick();
    cmd_valid = 1'b0;
    repeat (18) tick();
    total++;
    if (tx_serial !== 1'b0) begin bad++; $display("FAIL mid_bit3: got %b want 0", tx_serial); end
    reset_b = 1'b0;
    tick();
    total++; if (tx_serial !== 1'b1) begin bad++; $display("FAIL mid_rst_tx: got %b want 1", tx_serial); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (resp_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %02h want 00", resp_data); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", resp_err); end
    reset_b = 1'b1;
    tick();
    t0 = to_seen;
    send_cmd(8'h55, 1'b0);
`ifdef UART_QUERY_PARITY_EN
    send_rx(8'h81, 1'b1, 1'b1);
    expect_resp("mid_par", 8'h81, 1'b1, t0);
`else
    send_rx(8'h81, 1'b1, 1'b0);
    expect_resp("mid_resp", 8'h81, 1'b0, t0);
`endif
  endtask

  initial begin
    test_reset();
    test_query();
    test_timeout();
    test_framing_err();
    test_glitch_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
